// File: rtl/htif_pkg.sv
// Shared HTIF link definitions: opcodes, frame lengths, host FSM encoding
// and the frame packing helper, so both ends of the link agree on byte order.
package htif_pkg;

  localparam logic [7:0] HTIF_OP_READ   = 8'h01;
  localparam logic [7:0] HTIF_OP_WRITE  = 8'h02;

  localparam int         HTIF_FRAME_W   = 72;
  localparam logic [3:0] HTIF_LEN_READ  = 4'd5;
  localparam logic [3:0] HTIF_LEN_WRITE = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_CMD  = 3'd1,
    ST_SEND_ADDR = 3'd2,
    ST_SEND_DATA = 3'd3,
    ST_WAIT_RESP = 3'd4
  } htif_state_t;

  // Frame laid out so byte 0 (bits 7:0) goes out first: opcode, address LSB
  // first, then write data LSB first. Read frames carry zeros in the data slot.
  function automatic logic [HTIF_FRAME_W-1:0] htif_frame(
    input logic        write,
    input logic [31:0] address,
    input logic [31:0] data
  );
    htif_frame = {(write ? data : 32'h0), address,
                  (write ? HTIF_OP_WRITE : HTIF_OP_READ)};
  endfunction

endpackage

// File: rtl/htif_byte_ser.sv
// Byte serializer: loads a whole frame and shifts it out LSB byte first
// under a valid/ready handshake, one byte per cycle at full rate.
module htif_byte_ser
  import htif_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [HTIF_FRAME_W-1:0] frame,
  input  logic [3:0]              len,
  output logic                    busy,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data
);

  logic [HTIF_FRAME_W-1:0] shift;
  logic [3:0]              remain;
  logic                    xfer;

  assign xfer     = busy & tx_ready;
  assign tx_valid = busy;
  assign tx_data  = shift[7:0];

  // Frame shift register and byte countdown; the current byte only moves on a transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift  <= '0;
      remain <= '0;
      busy   <= 1'b0;
    end else if (load) begin
      shift  <= frame;
      remain <= len;
      busy   <= (len != 4'd0);
    end else if (xfer) begin
      shift  <= {8'h00, shift[HTIF_FRAME_W-1:8]};
      remain <= remain - 4'd1;
      busy   <= (remain != 4'd1);
    end
  end

endmodule

// File: rtl/htif_host.sv
// HTIF host initiator: turns word read/write requests into command frames
// on the byte link and reassembles 4-byte read responses, with a timeout.
module htif_host #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  output logic        req_ready,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_timeout,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        rx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);
  import htif_pkg::*;

  localparam logic [31:0] TIMEOUT_W  = 32'(TIMEOUT);
  localparam logic        TIMEOUT_EN = (TIMEOUT != 0);

  htif_state_t             state, state_next;
  logic [1:0]              idx, idx_next;
  logic                    is_write;
  logic                    ser_load, ser_busy, tx_xfer;
  logic [HTIF_FRAME_W-1:0] ser_frame;
  logic [3:0]              ser_len;
  logic                    resp_done, resp_expire, timer_hit;
  logic [31:0]             timer;
  logic [23:0]             res_shift;
  logic [15:0]             drop_count;

  assign req_ready = (state == ST_IDLE);
  assign rx_ready  = ~reset;
  assign tx_xfer   = ser_busy & tx_ready;
  assign timer_hit = TIMEOUT_EN && ((timer + 32'd1) == TIMEOUT_W);
  assign ser_frame = htif_frame(req_write, req_address, req_data);
  assign ser_len   = req_write ? HTIF_LEN_WRITE : HTIF_LEN_READ;

  htif_byte_ser u_ser (
    .clock    (clock),
    .reset    (reset),
    .load     (ser_load),
    .frame    (ser_frame),
    .len      (ser_len),
    .busy     (ser_busy),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data)
  );

  // State and byte index registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic; a 4th response byte beats a timeout landing on the same cycle.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    ser_load    = 1'b0;
    resp_done   = 1'b0;
    resp_expire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          ser_load   = 1'b1;
          state_next = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD: begin
        if (tx_xfer) begin
          state_next = ST_SEND_ADDR;
          idx_next   = 2'd0;
        end
      end
      ST_SEND_ADDR: begin
        if (tx_xfer) begin
          if (idx == 2'd3) begin
            state_next = is_write ? ST_SEND_DATA : ST_WAIT_RESP;
            idx_next   = 2'd0;
          end else begin
            idx_next = idx + 2'd1;
          end
        end
      end
      ST_SEND_DATA: begin
        if (tx_xfer) begin
          if (idx == 2'd3) begin
            state_next = ST_IDLE;
            idx_next   = 2'd0;
          end else begin
            idx_next = idx + 2'd1;
          end
        end
      end
      ST_WAIT_RESP: begin
        if (rx_valid && idx == 2'd3) begin
          resp_done  = 1'b1;
          state_next = ST_IDLE;
          idx_next   = 2'd0;
        end else if (timer_hit) begin
          resp_expire = 1'b1;
          state_next  = ST_IDLE;
          idx_next    = 2'd0;
        end else if (rx_valid) begin
          idx_next = idx + 2'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = 2'd0;
      end
    endcase
  end

  // Request kind remembered for the address-to-data/response branch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         is_write <= 1'b0;
    else if (ser_load) is_write <= req_write;
  end

  // Response timer: zero outside WAIT_RESP, so it starts fresh on every entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        timer <= '0;
    else if (state == ST_WAIT_RESP)   timer <= timer + 32'd1;
    else                              timer <= '0;
  end

  // Count rx bytes arriving when no response is expected, saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      drop_count <= '0;
    else if (rx_valid && state != ST_WAIT_RESP && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end

  // Response assembly and the one-cycle completion pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_shift   <= '0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      res_valid   <= resp_done | resp_expire;
      res_timeout <= resp_expire;
      if (resp_done)        res_data <= {rx_data, res_shift};
      else if (resp_expire) res_data <= '0;
      if (state == ST_WAIT_RESP && rx_valid) begin
        case (idx)
          2'd0:    res_shift[7:0]   <= rx_data;
          2'd1:    res_shift[15:8]  <= rx_data;
          2'd2:    res_shift[23:16] <= rx_data;
          default: res_shift        <= res_shift;
        endcase
      end
    end
  end

endmodule
